// File: rtl/wf_joystick_scan_sched.sv
// Scan scheduler and LED-frame arbiter for the joystick board serial driver.
// Optional switch debounce is built when WF_SCAN_DEBOUNCE_EN is defined.
module wf_joystick_scan_sched #(
  parameter int unsigned SCAN_TICKS  = 200,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned DEB_SCANS   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_10us,
  output logic        scan_enable,
  input  logic        scan_done,
  input  logic [12:0] sw_raw,
  input  logic [1:0]  req,
  input  logic [47:0] frame0,
  input  logic [47:0] frame1,
  output logic [1:0]  grant,
  output logic [47:0] led_frame,
  output logic [2:0]  col_idx,
  output logic        frame_start,
  output logic [12:0] sw_stable,
  output logic [12:0] sw_press,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned   PW       = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(SCAN_TICKS - 1);
  localparam logic [9:0]    WD_LAST  = 10'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic          pend_q, pend_d;
  logic [9:0]    wd_q, wd_d;
  logic [2:0]    col_q, col_d;
  logic          fs_q, fs_d;
  logic [1:0]    grant_q, grant_d, arb_win;
  logic          last_q, last_d;
  logic [47:0]   led_q, led_d;
  logic [12:0]   stable_q, stable_d, press_q, press_d;
  logic          ovr_q, ovr_d, tmo_q, tmo_d;
  logic          expire, busy, done_acc, wd_hit, boundary;

  always_comb begin
    busy     = (state_q == S_BUSY);
    expire   = tick_10us && (per_q == PER_LAST);
    done_acc = busy && scan_done;
    // A completion arriving on the last watchdog cycle wins over the timeout.
    wd_hit   = busy && !scan_done && (wd_q == WD_LAST);
    boundary = done_acc && (col_q == 3'd5);

    per_d = per_q;
    if (tick_10us) per_d = expire ? '0 : per_q + PW'(1);

    pend_d = pend_q;
    if (expire)                  pend_d = 1'b1;
    else if (state_q == S_ISSUE) pend_d = 1'b0;

    ovr_d = ovr_q | (expire & (pend_q | busy));
    tmo_d = tmo_q | wd_hit;

    wd_d = wd_q;
    if (state_q == S_ISSUE) wd_d = '0;
    else if (busy)          wd_d = wd_q + 10'd1;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pend_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_BUSY;
      S_BUSY: begin
        // A period that expired during the transfer reissues straight away.
        if (done_acc)    state_d = pend_q ? S_ISSUE : S_IDLE;
        else if (wd_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    col_d = col_q;
    if (done_acc) col_d = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;
    fs_d = boundary;
  end

  always_comb begin
    // Owner keeps the grant while requesting; otherwise the requesting side
    // (at most one remains) wins, with a tie going to the previous non-owner.
    if ((grant_q[0] && req[0]) || (grant_q[1] && req[1])) arb_win = grant_q;
    else if (req == 2'b11)                                arb_win = last_q ? 2'b01 : 2'b10;
    else                                                  arb_win = req;

    grant_d = grant_q;
    last_d  = last_q;
    led_d   = led_q;
    if (boundary) begin
      grant_d = arb_win;
      if (arb_win[0]) begin
        led_d  = frame0;
        last_d = 1'b0;
      end else if (arb_win[1]) begin
        led_d  = frame1;
        last_d = 1'b1;
      end
    end
  end

`ifdef WF_SCAN_DEBOUNCE_EN
  localparam logic [3:0] DEB_N = 4'(DEB_SCANS);
  logic [12:0][3:0] deb_q, deb_d;

  always_comb begin
    stable_d = stable_q;
    deb_d    = deb_q;
    if (done_acc) begin
      for (int unsigned i = 0; i < 13; i++) begin
        if (sw_raw[i] == stable_q[i]) begin
          deb_d[i] = '0;
        end else if (deb_q[i] + 4'd1 == DEB_N) begin
          stable_d[i] = ~stable_q[i];
          deb_d[i]    = '0;
        end else begin
          deb_d[i] = deb_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) deb_q <= '0;
    else       deb_q <= deb_d;
  end
`else
  always_comb begin
    stable_d = done_acc ? sw_raw : stable_q;
  end
`endif

  assign press_d = stable_d & ~stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      per_q    <= '0;
      pend_q   <= 1'b0;
      wd_q     <= '0;
      col_q    <= '0;
      fs_q     <= 1'b0;
      grant_q  <= '0;
      last_q   <= 1'b1;
      led_q    <= '0;
      stable_q <= '0;
      press_q  <= '0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      pend_q   <= pend_d;
      wd_q     <= wd_d;
      col_q    <= col_d;
      fs_q     <= fs_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      led_q    <= led_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign scan_enable = (state_q == S_ISSUE);
  assign grant       = grant_q;
  assign led_frame   = led_q;
  assign col_idx     = col_q;
  assign frame_start = fs_q;
  assign sw_stable   = stable_q;
  assign sw_press    = press_q;
  assign overrun     = ovr_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_wf_joystick_scan_sched.sv
// Directed bench for wf_joystick_scan_sched with a scoreboard of per-scan results.
// Follows WF_SCAN_DEBOUNCE_EN in its reference model when the macro is defined.
module tb_wf_joystick_scan_sched;
  localparam int unsigned SCAN_TICKS  = 3;
  localparam int unsigned TIMEOUT_CYC = 20;
  localparam int unsigned DEB_SCANS   = 4;
  localparam int          TICK_DIV    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_10us = 1'b0;
  logic        scan_done = 1'b0;
  logic [12:0] sw_raw = '0;
  logic [1:0]  req = '0;
  logic [47:0] frame0 = '0, frame1 = '0;
  logic        scan_enable, frame_start, overrun, timeout_err;
  logic [1:0]  grant;
  logic [47:0] led_frame;
  logic [2:0]  col_idx;
  logic [12:0] sw_stable, sw_press;

  wf_joystick_scan_sched #(
    .SCAN_TICKS(SCAN_TICKS), .TIMEOUT_CYC(TIMEOUT_CYC), .DEB_SCANS(DEB_SCANS)
  ) dut (
    .clk(clk), .reset(reset), .tick_10us(tick_10us), .scan_enable(scan_enable),
    .scan_done(scan_done), .sw_raw(sw_raw), .req(req), .frame0(frame0), .frame1(frame1),
    .grant(grant), .led_frame(led_frame), .col_idx(col_idx), .frame_start(frame_start),
    .sw_stable(sw_stable), .sw_press(sw_press), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  col;
    logic        fs;
    logic [1:0]  gnt;
    logic [47:0] led;
    logic [12:0] stab;
    logic [12:0] press;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, exp_cyc = -1000, prev_se = -1, last_done = -1000;

  logic [2:0]  m_col;
  logic [1:0]  m_grant;
  logic        m_last;
  logic [47:0] m_led;
  logic [12:0] m_stab;
  int          m_cnt[13];

  // Time base: a tick every TICK_DIV cycles, every SCAN_TICKS-th one expires the period.
  initial begin
    int tdiv, tcnt;
    bit r_seen;
    tdiv = 0;
    tcnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      r_seen = reset;
      #1;
      if (r_seen) begin
        tdiv = 0;
        tcnt = 0;
        tick_10us = 1'b0;
      end else begin
        tdiv++;
        if (tdiv == TICK_DIV) begin
          tdiv = 0;
          tick_10us = 1'b1;
          tcnt++;
          if (tcnt == int'(SCAN_TICKS)) begin
            tcnt = 0;
            exp_cyc = cyc;
          end
        end else begin
          tick_10us = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_col = '0; m_grant = '0; m_last = 1'b1; m_led = '0; m_stab = '0;
    foreach (m_cnt[b]) m_cnt[b] = 0;
    prev_se = -1;
    exp_q.delete();
  endtask

  task automatic wait_se(output int c, output bit ok);
    ok = 1'b0;
    c = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (scan_enable === 1'b1) begin
        ok = 1'b1;
        c = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_se"}, scan_enable, 0);
    check({tag, "_col"}, col_idx, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_led"}, led_frame, 0);
    check({tag, "_stable"}, sw_stable, 0);
    check({tag, "_press"}, sw_press, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_timeout"}, timeout_err, 0);
  endtask

  // mode 1: issue paced by period expiry; mode 2: reissue right after last done.
  task automatic do_scan(input int delay, input logic [12:0] raw, input int mode);
    int e;
    bit ok;
    exp_t x, y;
    logic [1:0] n;
    logic [12:0] old;
    wait_se(e, ok);
    check("se_arrive", ok, 1);
    if (!ok) return;
    if (mode == 1) begin
      check("issue_latency", e - exp_cyc, 2);
      if (prev_se >= 0) check("issue_period", e - prev_se, 15);
    end
    if (mode == 2) check("reissue_latency", e - last_done, 1);
    prev_se = (mode == 1) ? e : -1;
    repeat (delay) step();
    scan_done = 1'b1;
    sw_raw = raw;
    last_done = cyc;
    if (m_col == 3'd5) begin
      x.fs = 1'b1;
      m_col = 3'd0;
      if (m_grant == 2'b01 && req[0])      n = 2'b01;
      else if (m_grant == 2'b10 && req[1]) n = 2'b10;
      else if (m_grant == 2'b01)           n = req[1] ? 2'b10 : 2'b00;
      else if (m_grant == 2'b10)           n = req[0] ? 2'b01 : 2'b00;
      else if (req == 2'b11)               n = m_last ? 2'b01 : 2'b10;
      else                                 n = req;
      m_grant = n;
      if (n == 2'b01) begin m_led = frame0; m_last = 1'b0; end
      else if (n == 2'b10) begin m_led = frame1; m_last = 1'b1; end
    end else begin
      x.fs = 1'b0;
      m_col = m_col + 3'd1;
    end
    old = m_stab;
`ifdef WF_SCAN_DEBOUNCE_EN
    for (int b = 0; b < 13; b++) begin
      if (raw[b] == m_stab[b]) m_cnt[b] = 0;
      else begin
        m_cnt[b]++;
        if (m_cnt[b] == int'(DEB_SCANS)) begin
          m_stab[b] = ~m_stab[b];
          m_cnt[b] = 0;
        end
      end
    end
`else
    m_stab = raw;
`endif
    x.col = m_col; x.gnt = m_grant; x.led = m_led; x.stab = m_stab; x.press = m_stab & ~old;
    exp_q.push_back(x);
    step();
    scan_done = 1'b0;
    y = exp_q.pop_front();
    check("col_idx", col_idx, y.col);
    check("frame_start", frame_start, y.fs);
    check("grant", grant, y.gnt);
    check("led_frame", led_frame, y.led);
    check("sw_stable", sw_stable, y.stab);
    check("sw_press", sw_press, y.press);
  endtask

  initial begin
    int e, e2;
    bit ok;
    logic [12:0] raw;
    logic [5:0] pat3;
    model_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_all_zero("reset");

    // Completion outside BUSY must be ignored.
    step();
    scan_done = 1'b1;
    sw_raw = '1;
    step();
    scan_done = 1'b0;
    sw_raw = '0;
    step();
    check("idle_done_col", col_idx, 0);
    check("idle_done_stable", sw_stable, 0);

    // Regular pacing, column walk, arbitration and frame swaps on boundaries.
    req = 2'b11;
    frame0 = 48'hA5A5_0F0F_1234;
    frame1 = 48'h5A5A_F0F0_CDEF;
    pat3 = 6'b111101;
    for (int i = 0; i < 18; i++) begin
      raw = '0;
      raw[3] = (i < 6) ? pat3[i] : 1'b1;
      raw[0] = (i >= 1);
      raw[12] = (i % 2 == 1);
      if (i == 8) req = 2'b10;
      if (i == 9) frame1 = 48'h0123_4567_89AB;
      if (i == 13) req = 2'b00;
      if (i == 14) begin
        frame1 = 48'hFFFF_0000_FFFF;
        frame0 = 48'h1111_2222_3333;
      end
      do_scan(10, raw, 1);
    end
    check("no_overrun_yet", overrun, 0);
    check("no_timeout_yet", timeout_err, 0);

    // Overrun: transfer outlasts the period, next issue follows completion.
    do_scan(18, 13'h0009, 1);
    check("overrun_set", overrun, 1);
    do_scan(10, 13'h0009, 2);

    // Timeout: never complete the transfer.
    wait_se(e, ok);
    check("to_se_arrive", ok, 1);
    repeat (TIMEOUT_CYC) step();
    check("timeout_before", timeout_err, 0);
    step();
    check("timeout_after", timeout_err, 1);
    check("timeout_col_hold", col_idx, m_col);
    wait_se(e2, ok);
    check("to_reissue_arrive", ok, 1);
    check("to_reissue_cycle", e2 - e, 22);
    do_scan(10, 13'h0009, 0);

    // Reset while BUSY; a later completion is ignored.
    wait_se(e, ok);
    check("rb_se_arrive", ok, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    scan_done = 1'b1;
    sw_raw = '1;
    step();
    scan_done = 1'b0;
    sw_raw = '0;
    check_all_zero("reset_busy");
    do_scan(10, 13'h0008, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
